vc_writeback_engine: RTL

- Drains dirty (M-state) lines out of the L1.5 victim cache toward L2 over the NoC request channel, then tells the victim cache to release the entry once L2 acknowledges.
- Buffers up to BUF_DEPTH dirty lines and serializes each one into a 3-flit writeback message (header plus two data flits).
- Tracks up to MAX_OUTSTANDING unacknowledged writebacks.

---
 rtl/vc_writeback_engine_if.sv | 34 +++
 rtl/vc_writeback_engine.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/vc_writeback_engine_if.sv
// Signal bundle between the writeback engine, the L1.5 victim cache and the NoC request channel.
// slave is the engine's view; master is the view of the surrounding victim cache / NoC / L2.
interface vc_writeback_engine_if #(
    parameter int IDX_W  = 4,
    parameter int ADDR_W = 36,
    parameter int LINE_W = 128,
    parameter int FLIT_W = 64
);
    logic              vc_wb_val;
    logic [IDX_W-1:0]  vc_wb_index;
    logic [ADDR_W-1:0] vc_wb_addr;
    logic [LINE_W-1:0] vc_wb_data;
    logic              wb_vc_rdy;
    logic              wb_noc_val;
    logic [FLIT_W-1:0] wb_noc_flit;
    logic              wb_noc_rdy;
    logic              noc_wb_ack_val;
    logic              wb_vc_done_val;
    logic [IDX_W-1:0]  wb_vc_done_index;
    logic              wb_busy;
    logic              wb_err;

    modport slave (
        input  vc_wb_val, vc_wb_index, vc_wb_addr, vc_wb_data, wb_noc_rdy, noc_wb_ack_val,
        output wb_vc_rdy, wb_noc_val, wb_noc_flit, wb_vc_done_val, wb_vc_done_index,
               wb_busy, wb_err
    );

    modport master (
        output vc_wb_val, vc_wb_index, vc_wb_addr, vc_wb_data, wb_noc_rdy, noc_wb_ack_val,
        input  wb_vc_rdy, wb_noc_val, wb_noc_flit, wb_vc_done_val, wb_vc_done_index,
               wb_busy, wb_err
    );
endinterface

// File: rtl/vc_writeback_engine.sv
// Victim-cache writeback engine: buffers dirty lines, sends each as a 3-flit NoC message,
// and releases the victim cache entry when L2 acknowledges (acks arrive in order).
module vc_writeback_engine #(
    parameter int VC_ENTRIES      = 16,
    parameter int ADDR_W          = 36,
    parameter int LINE_W          = 128,
    parameter int FLIT_W          = 64,
    parameter int BUF_DEPTH       = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input logic clk,
    input logic rst,
    vc_writeback_engine_if.slave bus
);
    localparam int IDX_W = $clog2(VC_ENTRIES);
    localparam int BP_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int BC_W  = $clog2(BUF_DEPTH + 1);
    localparam int OP_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int OC_W  = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [BC_W-1:0] BUF_FULL = BC_W'(BUF_DEPTH);
    localparam logic [BC_W-1:0] BUF_ONE  = BC_W'(1);
    localparam logic [OC_W-1:0] OUT_MAX  = OC_W'(MAX_OUTSTANDING);
    localparam logic [OC_W-1:0] OUT_LAST = OC_W'(MAX_OUTSTANDING - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_D0   = 2'd2;
    localparam logic [1:0] S_D1   = 2'd3;

    logic [IDX_W-1:0]  buf_index [BUF_DEPTH];
    logic [ADDR_W-1:0] buf_addr  [BUF_DEPTH];
    logic [LINE_W-1:0] buf_data  [BUF_DEPTH];
    logic [BP_W-1:0]   buf_wr, buf_rd;
    logic [BC_W-1:0]   buf_count, buf_count_next;
    logic              rdy_q;

    logic [IDX_W-1:0]  out_index [MAX_OUTSTANDING];
    logic [OP_W-1:0]   out_wr, out_rd;
    logic [OC_W-1:0]   out_count;

    logic [1:0]        state;
    logic [FLIT_W-1:0] flit;
    logic              done_val;
    logic [IDX_W-1:0]  done_index;
    logic              err;

    logic              push, pop, ack_ok, start_idle, start_next;
    logic [BP_W-1:0]   hdr_slot;
    logic              hdr_from_buf;
    logic [ADDR_W-1:0] hdr_addr;
    logic [FLIT_W-1:0] hdr_flit;
    logic [LINE_W-1:0] head_data;

    function automatic logic [BP_W-1:0] buf_inc(input logic [BP_W-1:0] p);
        return (p == BP_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [OP_W-1:0] out_inc(input logic [OP_W-1:0] p);
        return (p == OP_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push       = bus.vc_wb_val && rdy_q;
    assign pop        = (state == S_D1) && bus.wb_noc_rdy;
    assign ack_ok     = bus.noc_wb_ack_val && (out_count != '0);
    assign head_data  = buf_data[buf_rd];
    assign start_idle = ((buf_count != '0) || push) && (out_count < OUT_MAX);
    // Chaining from D1 must leave room for the message being retired this cycle.
    assign start_next = ((buf_count > BUF_ONE) || push) && (out_count < OUT_LAST);

    // The next header comes from the buffer when a line is waiting there, else from the
    // line being accepted this cycle (which lets an idle engine send it one cycle later).
    always_comb begin
        hdr_slot     = (state == S_D1) ? buf_inc(buf_rd) : buf_rd;
        hdr_from_buf = (state == S_D1) ? (buf_count > BUF_ONE) : (buf_count != '0);
        hdr_addr     = hdr_from_buf ? buf_addr[hdr_slot] : bus.vc_wb_addr;
        hdr_flit     = {4'b1010, {(FLIT_W - 4 - ADDR_W){1'b0}}, hdr_addr};
    end

    always_comb begin
        buf_count_next = buf_count;
        if (push && !pop)
            buf_count_next = buf_count + 1'b1;
        else if (pop && !push)
            buf_count_next = buf_count - 1'b1;
    end

    // NOTE: the storage arrays carry no reset; count and pointers alone say what is valid,
    // which keeps the wide data RAM free of reset fan-out.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_index[buf_wr] <= bus.vc_wb_index;
            buf_addr[buf_wr]  <= bus.vc_wb_addr;
            buf_data[buf_wr]  <= bus.vc_wb_data;
        end
        if (pop)
            out_index[out_wr] <= buf_index[buf_rd];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_wr    <= '0;
            buf_rd    <= '0;
            buf_count <= '0;
            rdy_q     <= 1'b0;
        end else begin
            if (push) buf_wr <= buf_inc(buf_wr);
            if (pop)  buf_rd <= buf_inc(buf_rd);
            buf_count <= buf_count_next;
            rdy_q     <= (buf_count_next != BUF_FULL);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            flit  <= '0;
        end else begin
            case (state)
                S_IDLE: if (start_idle) begin
                    state <= S_HDR;
                    flit  <= hdr_flit;
                end
                S_HDR: if (bus.wb_noc_rdy) begin
                    state <= S_D0;
                    flit  <= head_data[FLIT_W-1:0];
                end
                S_D0: if (bus.wb_noc_rdy) begin
                    state <= S_D1;
                    flit  <= head_data[2*FLIT_W-1:FLIT_W];
                end
                default: if (bus.wb_noc_rdy) begin
                    if (start_next) begin
                        state <= S_HDR;
                        flit  <= hdr_flit;
                    end else begin
                        state <= S_IDLE;
                        flit  <= '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_wr     <= '0;
            out_rd     <= '0;
            out_count  <= '0;
            done_val   <= 1'b0;
            done_index <= '0;
            err        <= 1'b0;
        end else begin
            if (pop)    out_wr <= out_inc(out_wr);
            if (ack_ok) out_rd <= out_inc(out_rd);
            if (pop && !ack_ok)
                out_count <= out_count + 1'b1;
            else if (ack_ok && !pop)
                out_count <= out_count - 1'b1;
            done_val <= ack_ok;
            if (ack_ok)
                done_index <= out_index[out_rd];
            if (bus.noc_wb_ack_val && (out_count == '0))
                err <= 1'b1;
        end
    end

    assign bus.wb_vc_rdy        = rdy_q;
    assign bus.wb_noc_val       = (state != S_IDLE);
    assign bus.wb_noc_flit      = flit;
    assign bus.wb_vc_done_val   = done_val;
    assign bus.wb_vc_done_index = done_index;
    assign bus.wb_busy          = (buf_count != '0) || (state != S_IDLE) || (out_count != '0);
    assign bus.wb_err           = err;
endmodule
